// File: rtl/multi_debouncer_if.sv
// Pin-side bundle for the multi-channel debouncer: raw inputs in, conditioned levels/strobes out.
// Latency: none, this is wiring only.
// Backpressure: none; every signal is a free-running level or a one-cycle strobe.
// Ports: bouncy_in (raw pins), debounced_out, rise, fall, long_press, long_held (one bit per channel).
interface multi_debouncer_if #(
    parameter int N = 4
);
    logic [N-1:0] bouncy_in;
    logic [N-1:0] debounced_out;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] long_press;
    logic [N-1:0] long_held;

    // master: whoever owns the pins and consumes the conditioned results
    modport master (
        output bouncy_in,
        input  debounced_out, rise, fall, long_press, long_held
    );

    // slave: the debouncer itself
    modport slave (
        input  bouncy_in,
        output debounced_out, rise, fall, long_press, long_held
    );
endinterface

// File: rtl/multi_debouncer.sv
// N-channel button conditioner: synchroniser, glitch-rejecting debounce FSM, rise/fall strobes, long-press.
// Latency: a clean level change appears SYNC_STAGES+BOUNCE_TICKS+1 clk edges after it is first sampled.
// Backpressure: none; strobes are single-cycle and must be consumed when they appear.
// Ports: clk, rst (sync, active-high), bus (slave modport: bouncy_in in; debounced_out, rise, fall,
//        long_press, long_held out, all N bits wide and all driven from flops).
module multi_debouncer #(
    parameter int N            = 4,
    parameter int BOUNCE_TICKS = 10,
    parameter int SYNC_STAGES  = 2,
    parameter int LONG_TICKS   = 1000
) (
    input  logic               clk,
    input  logic               rst,
    multi_debouncer_if.slave   bus
);
    localparam int CNT_W  = $clog2(BOUNCE_TICKS);
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BOUNCE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

    typedef enum logic [1:0] {
        S_0       = 2'd0,
        S_MAYBE_1 = 2'd1,
        S_1       = 2'd2,
        S_MAYBE_0 = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q [N];
    logic [N-1:0]           sync;

    state_t                 state_q [N];
    state_t                 state_d [N];
    logic [CNT_W-1:0]       cnt_q   [N];
    logic [CNT_W-1:0]       cnt_d   [N];
    logic [HOLD_W-1:0]      hold_q  [N];
    logic [HOLD_W-1:0]      hold_d  [N];

    logic [N-1:0] rise_d, fall_d, lp_d, held_d;
    logic [N-1:0] rise_q, fall_q, lp_q, held_q;

    always_comb begin
        sync = '0;
        for (int i = 0; i < N; i++) begin
            sync[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Debounce FSM, bounce counter and hold counter, one copy per channel.
    always_comb begin
        rise_d = '0;
        fall_d = '0;
        lp_d   = '0;
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            hold_d[i]  = hold_q[i];

            case (state_q[i])
                S_0: begin
                    if (sync[i]) begin
                        state_d[i] = S_MAYBE_1;
                        cnt_d[i]   = '0;
                    end
                end
                S_MAYBE_1: begin
                    if (!sync[i]) begin
                        state_d[i] = S_0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = S_1;
                        rise_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                S_1: begin
                    if (!sync[i]) begin
                        state_d[i] = S_MAYBE_0;
                        cnt_d[i]   = '0;
                    end
                end
                S_MAYBE_0: begin
                    // Returning to S_1 is a dropout, not a new press: no strobe, hold count kept.
                    if (sync[i]) begin
                        state_d[i] = S_1;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = S_0;
                        fall_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = S_0;
                end
            endcase

            // Hold counter restarts on the rise and saturates, so only one long_press per press.
            if (rise_d[i]) begin
                hold_d[i] = '0;
            end else if ((state_q[i] == S_1 || state_q[i] == S_MAYBE_0) && hold_q[i] < HOLD_MAX) begin
                hold_d[i] = hold_q[i] + 1'b1;
                lp_d[i]   = (hold_q[i] == HOLD_LAST);
            end
        end
    end

    // The fall wins over a coincident long_press so long_held never outlives the press.
    always_comb begin
        held_d = (held_q | lp_d) & ~fall_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                sync_q[i]  <= '0;
                state_q[i] <= S_0;
                cnt_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
            rise_q <= '0;
            fall_q <= '0;
            lp_q   <= '0;
            held_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], bus.bouncy_in[i]};
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                hold_q[i]  <= hold_d[i];
            end
            rise_q <= rise_d;
            fall_q <= fall_d;
            lp_q   <= lp_d;
            held_q <= held_d;
        end
    end

    // Level decoded straight from the state register: no path from the raw pins.
    always_comb begin
        bus.debounced_out = '0;
        for (int i = 0; i < N; i++) begin
            bus.debounced_out[i] = (state_q[i] == S_1) || (state_q[i] == S_MAYBE_0);
        end
    end

    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.long_press = lp_q;
    assign bus.long_held  = held_q;
endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with a per-channel strobe scoreboard.
// Latency: strobes are expected exactly SYNC_STAGES+BOUNCE_TICKS+1 edges after a clean input change.
// Backpressure: none; every strobe seen is matched against the next expected event for its channel.
module tb_multi_debouncer;
    localparam int N    = 4;
    localparam int LAT  = 13;   // SYNC_STAGES + BOUNCE_TICKS + 1 with 2 / 10
    localparam int LONG = 20;

    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_LP   = 2;

    typedef struct {
        int ch;
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  exp_q[$];

    int   mon_idx;
    logic mon_hit;

    multi_debouncer_if #(.N(N)) bus ();

    multi_debouncer #(
        .N(N), .BOUNCE_TICKS(10), .SYNC_STAGES(2), .LONG_TICKS(LONG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic push(input int ch, input int kind, input int at);
        ev_t e;
        e.ch = ch; e.kind = kind; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dbo"},  32'(bus.debounced_out), 32'h0);
        chk({tag, "_rise"}, 32'(bus.rise),          32'h0);
        chk({tag, "_fall"}, 32'(bus.fall),          32'h0);
        chk({tag, "_lp"},   32'(bus.long_press),    32'h0);
        chk({tag, "_held"}, 32'(bus.long_held),     32'h0);
    endtask

    // Scoreboard side: each strobe pops the oldest pending event of its channel.
    always @(negedge clk) begin
        n_cmp++;
        assert ((bus.rise & bus.fall) === '0) else begin
            n_bad++;
            $error("FAIL rise_and_fall: observed rise %b fall %b, required disjoint", bus.rise, bus.fall);
        end
        for (int ch = 0; ch < N; ch++) begin
            for (int k = 0; k < 3; k++) begin
                mon_hit = (k == K_RISE) ? bus.rise[ch] : (k == K_FALL) ? bus.fall[ch] : bus.long_press[ch];
                if (mon_hit === 1'b1) begin
                    mon_idx = -1;
                    for (int j = exp_q.size() - 1; j >= 0; j--) begin
                        if (exp_q[j].ch == ch) mon_idx = j;
                    end
                    n_cmp++;
                    if (mon_idx < 0) begin
                        n_bad++;
                        $error("FAIL strobe ch%0d: observed kind %0d at cycle %0d, expected none", ch, k, cyc);
                    end else begin
                        assert (exp_q[mon_idx].kind === k && exp_q[mon_idx].cyc === cyc) else begin
                            n_bad++;
                            $error("FAIL strobe ch%0d: observed kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                                   ch, k, cyc, exp_q[mon_idx].kind, exp_q[mon_idx].cyc);
                        end
                        exp_q.delete(mon_idx);
                    end
                end
            end
        end
    end

    initial begin
        int c, r, x;
        bus.bouncy_in = '0;
        rst = 1'b1;
        tick(3);
        chk_all_zero("reset");
        rst = 1'b0;
        tick(2);

        // 1: clean press and release on channel 0
        c = cyc;
        bus.bouncy_in[0] = 1'b1;
        push(0, K_RISE, c + LAT);
        push(0, K_FALL, c + 1 + 2 * LAT);
        wait_until(c + LAT - 1);
        chk("t1_dbo_before", 32'(bus.debounced_out), 32'h0);
        tick(1);
        chk("t1_dbo_edge13", 32'(bus.debounced_out), 32'h1);
        chk("t1_rise_edge13", 32'(bus.rise), 32'h1);
        tick(1);
        chk("t1_rise_one_cycle", 32'(bus.rise), 32'h0);
        bus.bouncy_in[0] = 1'b0;
        wait_until(c + 1 + 2 * LAT);
        chk("t1_fall", 32'(bus.fall), 32'h1);
        chk("t1_dbo_low", 32'(bus.debounced_out), 32'h0);
        tick(3);

        // 2: glitch and a 9-cycle pulse on channel 1 are rejected
        bus.bouncy_in[1] = 1'b1;
        tick(1);
        bus.bouncy_in[1] = 1'b0;
        tick(4);
        bus.bouncy_in[1] = 1'b1;
        tick(5);
        chk("t2_dbo_mid_pulse", 32'(bus.debounced_out), 32'h0);
        tick(4);
        bus.bouncy_in[1] = 1'b0;
        tick(20);
        chk("t2_dbo_after", 32'(bus.debounced_out), 32'h0);

        // 3: bouncing press and bouncing release on channel 2
        for (int t = 0; t < 6; t++) begin
            bus.bouncy_in[2] = ~bus.bouncy_in[2];
            tick(3);
        end
        c = cyc;
        bus.bouncy_in[2] = 1'b1;
        push(2, K_RISE, c + LAT);
        push(2, K_LP,   c + LAT + LONG);
        wait_until(c + LAT);
        chk("t3_dbo_rise", 32'(bus.debounced_out), 32'h4);
        tick(1);
        for (int t = 0; t < 4; t++) begin
            bus.bouncy_in[2] = ~bus.bouncy_in[2];
            tick(2);
        end
        x = cyc;
        bus.bouncy_in[2] = 1'b0;
        push(2, K_FALL, x + LAT);
        wait_until(x + LAT - 1);
        chk("t3_held_before_fall", 32'(bus.long_held), 32'h4);
        tick(1);
        chk("t3_held_cleared", 32'(bus.long_held), 32'h0);
        chk("t3_dbo_low", 32'(bus.debounced_out), 32'h0);
        tick(3);

        // 4a: long hold on channel 3, one long_press only
        c = cyc;
        r = c + LAT;
        bus.bouncy_in[3] = 1'b1;
        push(3, K_RISE, r);
        push(3, K_LP,   r + LONG);
        wait_until(r + LONG - 1);
        chk("t4_lp_early", 32'(bus.long_press), 32'h0);
        chk("t4_held_early", 32'(bus.long_held), 32'h0);
        tick(1);
        chk("t4_lp", 32'(bus.long_press), 32'h8);
        chk("t4_held", 32'(bus.long_held), 32'h8);
        tick(1);
        chk("t4_lp_one_cycle", 32'(bus.long_press), 32'h0);
        chk("t4_held_level", 32'(bus.long_held), 32'h8);
        wait_until(r + 120);
        x = cyc;
        bus.bouncy_in[3] = 1'b0;
        push(3, K_FALL, x + LAT);
        wait_until(x + LAT - 1);
        chk("t4_held_until_fall", 32'(bus.long_held), 32'h8);
        tick(1);
        chk("t4_held_clear", 32'(bus.long_held), 32'h0);
        tick(3);

        // 4b: fall 19 cycles after rise gives no long_press
        c = cyc;
        r = c + LAT;
        bus.bouncy_in[3] = 1'b1;
        push(3, K_RISE, r);
        push(3, K_FALL, r + LONG - 1);
        wait_until(r + 6);
        bus.bouncy_in[3] = 1'b0;
        wait_until(r + LONG - 1);
        chk("t4b_fall", 32'(bus.fall), 32'h8);
        tick(3);
        chk("t4b_no_held", 32'(bus.long_held), 32'h0);

        // 5: 5-cycle dropout during a held press on channel 0
        c = cyc;
        r = c + LAT;
        bus.bouncy_in[0] = 1'b1;
        push(0, K_RISE, r);
        push(0, K_LP,   r + LONG);
        wait_until(r + 3);
        bus.bouncy_in[0] = 1'b0;
        tick(5);
        bus.bouncy_in[0] = 1'b1;
        wait_until(r + 9);
        chk("t5_dbo_dropout", 32'(bus.debounced_out), 32'h1);
        wait_until(r + LONG);
        chk("t5_lp", 32'(bus.long_press), 32'h1);
        wait_until(r + 25);
        bus.bouncy_in[0] = 1'b0;
        push(0, K_FALL, r + 25 + LAT);
        wait_until(r + 25 + LAT);
        chk("t5_held_clear", 32'(bus.long_held), 32'h0);
        tick(3);

        // 6a: all channels together
        c = cyc;
        bus.bouncy_in = '1;
        for (int ch = 0; ch < N; ch++) push(ch, K_RISE, c + LAT);
        for (int ch = 0; ch < N; ch++) push(ch, K_FALL, c + 1 + 2 * LAT);
        wait_until(c + LAT);
        chk("t6_rise_all", 32'(bus.rise), 32'hF);
        tick(1);
        bus.bouncy_in = '0;
        wait_until(c + 1 + 2 * LAT);
        chk("t6_fall_all", 32'(bus.fall), 32'hF);
        tick(3);

        // 6b: reset with bounce counters at 5, input kept high through release
        c = cyc;
        bus.bouncy_in = '1;
        wait_until(c + 8);
        rst = 1'b1;
        tick(1);
        chk_all_zero("rst_mid");
        tick(1);
        chk_all_zero("rst_held");
        rst = 1'b0;
        x = cyc;
        for (int ch = 0; ch < N; ch++) push(ch, K_RISE, x + LAT);
        wait_until(x + LAT - 1);
        chk("t6_dbo_before", 32'(bus.debounced_out), 32'h0);
        tick(1);
        chk("t6_dbo_after_rst", 32'(bus.debounced_out), 32'hF);
        tick(2);
        bus.bouncy_in = '0;
        for (int ch = 0; ch < N; ch++) push(ch, K_FALL, x + LAT + 2 + LAT);
        wait_until(x + 2 * LAT + 5);

        chk("pending_events", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
N-channel button/switch conditioner: per-channel input synchroniser, glitch-rejecting debounce FSM, single-cycle rise/fall strobes, and long-press detection. Sits between raw board pins (buttons, switches, encoder contacts) and the user-interface / drawing-control logic. It replaces per-pin single-channel debouncers, which neither synchronise nor detect edges.

Parameters:
N, 4, number of independent channels (>=1)
BOUNCE_TICKS, 10, consecutive stable synchronised cycles required to accept a level change (>=2)
SYNC_STAGES, 2, flops in each input synchroniser chain (>=2)
LONG_TICKS, 1000, cycles after a rise before long_press fires (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
bouncy_in  input  N  raw asynchronous inputs, active-high
debounced_out  output  N  debounced level per channel
rise  output  N  one-cycle strobe on the first cycle debounced_out[i] is 1
fall  output  N  one-cycle strobe on the first cycle debounced_out[i] is 0 after being 1
long_press  output  N  one-cycle strobe when channel i has been debounced-high for LONG_TICKS cycles
long_held  output  N  level: high from the long_press strobe cycle until debounced_out[i] falls

Behaviour:
- Reset (synchronous, active-high, clk): clears all synchroniser flops, puts every FSM in S_0, and clears bounce and hold counters. All outputs are 0 in the cycle after the reset edge, including while rst is held.
- Synchroniser: a SYNC_STAGES-deep flop chain per channel. sync[i] is the last stage. The FSM uses only sync[i].
- Per-channel FSM states: S_0, S_MAYBE_1, S_1, S_MAYBE_0.
  - S_0: if sync=1, go to S_MAYBE_1 and set cnt=0.
  - S_MAYBE_1:
    - If sync=0, go to S_0. This is glitch rejection: no output change.
    - Else if cnt==BOUNCE_TICKS-1, go to S_1.
    - Else cnt++.
  - S_1: if sync=0, go to S_MAYBE_0 and set cnt=0.
  - S_MAYBE_0:
    - If sync=1, go to S_1. No fall; the hold counter is kept.
    - Else if cnt==BOUNCE_TICKS-1, go to S_0.
    - Else cnt++.
  - Any illegal encoding goes to S_0.
- debounced_out[i] = 1 in S_1 and S_MAYBE_0; 0 in S_0 and S_MAYBE_1. It is decoded from the state register, so there is no combinational path from bouncy_in.
- Latency:
  - A clean 0->1 at bouncy_in, first sampled at edge 1, makes debounced_out high after edge SYNC_STAGES+BOUNCE_TICKS+1. With defaults that is edge 13.
  - A clean 1->0 uses the same latency.
  - Any pulse shorter than BOUNCE_TICKS synchronised cycles produces no output change.
- rise/fall:
  - rise[i] is registered and high exactly in the cycle state enters S_1 from S_MAYBE_1.
  - fall[i] is high exactly in the cycle state enters S_0 from S_MAYBE_0.
  - The S_MAYBE_0->S_1 transition produces no strobe.
  - rise and fall are never high together on one channel.
- Hold counter:
  - Width $clog2(LONG_TICKS+1).
  - Cleared on the S_MAYBE_1->S_1 transition.
  - Increments each cycle in S_1 or S_MAYBE_0 while < LONG_TICKS, then saturates at LONG_TICKS.
  - long_press[i] is high only in the cycle the counter reaches LONG_TICKS. This is exactly LONG_TICKS cycles after the rise cycle.
  - long_held[i] rises with long_press and clears in the fall cycle.
  - Exactly one long_press per press, regardless of hold length.
  - A press released before LONG_TICKS gives no long_press.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Reset mid-operation: reset during S_MAYBE_x, or with the hold counter partially counted, discards all progress. No strobes are emitted in the reset cycle or the cycle after.
- bouncy_in held high through reset release: treated as a fresh press, so rise appears SYNC_STAGES+BOUNCE_TICKS+1 edges after release.

Test Plan:
1. Defaults; reset, then bouncy_in[0] driven 0->1 clean -> debounced_out[0]=1 and rise[0]=1 for one cycle after edge 13; other channels stay 0 and no strobes.
2. Channel 1 gets a 1-cycle glitch, then a high pulse of BOUNCE_TICKS-1=9 synchronised cycles -> debounced_out[1], rise[1] and fall[1] never assert.
3. Bouncing press: channel 2 toggles 6 times at 3-cycle spacing, then holds 1 -> exactly one rise[2], 13 edges after the last 0->1 transition; release with bounce -> exactly one fall[2].
4. LONG_TICKS=20; hold channel 3 high -> long_press[3] pulses exactly 20 cycles after rise[3]; long_held[3]=1 until the fall cycle; hold 100 more cycles -> no second pulse. Release at 19 cycles after rise -> no long_press.
5. A 5-cycle low dropout during a held press (S_MAYBE_0 abort) -> no fall and no rise; the hold counter continues and long_press timing is unchanged.
6. All N channels pressed on the same cycle -> all rise bits assert together. Assert rst mid-debounce (cnt=5) -> all outputs 0 next cycle and no strobes; a held input re-debounces 13 edges after reset release.
